// File: rtl/alu_reg_pipe_if.sv
// Operand/opcode request and result/flag response handshakes for alu_reg_pipe.
interface alu_reg_pipe_if #(
  parameter int N = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         err;

  modport master (
    output in_valid, a, b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result,
    input  flag_z, flag_n, flag_c, flag_v, err
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, out_ready,
    output in_ready, out_valid, result,
    output flag_z, flag_n, flag_c, flag_v, err
  );
endinterface

// File: rtl/alu_reg_pipe.sv
// Registered ALU with accumulator, shifts and optional shift-add multiplier.
// Define ALU_REG_PIPE_MUL_EN to build the iterative MUL (opcode 1100).
module alu_reg_pipe #(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input logic           clk,
  input logic           rst_n,
  alu_reg_pipe_if.slave io
);
  logic [N-1:0]   result_q, result_d;
  logic [N-1:0]   acc_q, acc_d;
  logic           fz_q, fz_d, fn_q, fn_d;
  logic           fc_q, fc_d, fv_q, fv_d;
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   r;
  logic           c, v, e;
  logic [N:0]     add_s, sub_s, acc_s, shl_x, shr_x;
  logic [SHW-1:0] sh;
  logic           out_free, accept;

`ifdef ALU_REG_PIPE_MUL_EN
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t       state_q, state_d;
  logic [N-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [N-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign io.in_ready = (state_q == S_IDLE) & out_free;
`else
  assign io.in_ready = out_free;
`endif

  assign out_free = ~out_valid_q | io.out_ready;
  assign accept   = io.in_valid & io.in_ready;
  assign sh       = io.b[SHW-1:0];
  assign add_s    = {1'b0, io.a} + {1'b0, io.b};
  assign sub_s    = {1'b0, io.a} - {1'b0, io.b};
  assign acc_s    = {1'b0, acc_q} + {1'b0, io.a};
  assign shl_x    = {1'b0, io.a} << sh;
  assign shr_x    = {io.a, 1'b0} >> sh;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    unique case (io.alu_ctrl)
      4'h0: r = ~io.a;
      4'h1: r = io.a & io.b;
      4'h2: r = io.a | io.b;
      4'h3: r = io.a ^ io.b;
      4'h4: begin
        r = add_s[N-1:0];
        c = add_s[N];
        v = (io.a[N-1] == io.b[N-1]) && (add_s[N-1] != io.a[N-1]);
      end
      4'h5: begin
        r = sub_s[N-1:0];
        c = sub_s[N];
        v = (io.a[N-1] != io.b[N-1]) && (sub_s[N-1] != io.a[N-1]);
      end
      4'h6: r = {{(N-1){1'b0}}, io.a <  io.b};
      4'h7: r = {{(N-1){1'b0}}, io.a <= io.b};
      4'h8: r = {{(N-1){1'b0}}, io.a >  io.b};
      4'h9: r = {{(N-1){1'b0}}, io.a >= io.b};
      4'hA: r = {{(N-1){1'b0}}, io.a == io.b};
      4'hB: r = {{(N-1){1'b0}}, io.a != io.b};
`ifdef ALU_REG_PIPE_MUL_EN
      4'hC: r = '0;
`else
      4'hC: e = 1'b1;
`endif
      4'hD: begin
        r = shl_x[N-1:0];
        c = shl_x[N];
      end
      4'hE: begin
        r = shr_x[N:1];
        c = shr_x[0];
      end
      4'hF: begin
        r = acc_s[N-1:0];
        c = acc_s[N];
        v = (acc_q[N-1] == io.a[N-1]) && (acc_s[N-1] != acc_q[N-1]);
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    fz_d        = fz_q;
    fn_d        = fn_q;
    fc_d        = fc_q;
    fv_d        = fv_q;
    err_d       = err_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q & ~io.out_ready;
`ifdef ALU_REG_PIPE_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    if (accept) begin
`ifdef ALU_REG_PIPE_MUL_EN
      if (io.alu_ctrl == 4'hC) begin
        mcand_d  = io.a;
        mplier_d = io.b;
        prod_d   = '0;
        cnt_d    = CW'(N);
        state_d  = S_MUL;
      end else
`endif
      begin
        result_d    = r;
        fz_d        = ~|r;
        fn_d        = r[N-1];
        fc_d        = c;
        fv_d        = v;
        err_d       = e;
        out_valid_d = 1'b1;
        if (io.alu_ctrl == 4'hF) acc_d = acc_s[N-1:0];
      end
    end
`ifdef ALU_REG_PIPE_MUL_EN
    unique case (state_q)
      S_MUL: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_free) begin
          result_d    = prod_q;
          fz_d        = ~|prod_q;
          fn_d        = prod_q[N-1];
          fc_d        = 1'b0;
          fv_d        = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      acc_q       <= '0;
      fz_q        <= 1'b0;
      fn_q        <= 1'b0;
      fc_q        <= 1'b0;
      fv_q        <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      acc_q       <= acc_d;
      fz_q        <= fz_d;
      fn_q        <= fn_d;
      fc_q        <= fc_d;
      fv_q        <= fv_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_REG_PIPE_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.flag_z    = fz_q;
  assign io.flag_n    = fn_q;
  assign io.flag_c    = fc_q;
  assign io.flag_v    = fv_q;
  assign io.err       = err_q;
endmodule

// File: tb/tb_alu_reg_pipe.sv
// Directed vector bench for alu_reg_pipe at N=4.
module tb_alu_reg_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_reg_pipe_if #(.N(4)) io ();

  alu_reg_pipe #(.N(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b);
    io.alu_ctrl = op;
    io.a        = a;
    io.b        = b;
    io.in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  lat;
    bit  done;
    bit  seen;
    // op a b | r z n c v
    tbl[0]  = '{4'hF, 4'h3, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'hF, 4'h3, 4'h0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'hF, 4'h3, 4'h0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{4'h4, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{4'h5, 4'h0, 4'h1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{4'h6, 4'h2, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'hA, 4'hA, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'hB, 4'hA, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'h0, 4'h5, 4'h0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'h1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'h2, 4'hC, 4'h3, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'h3, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'h7, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'h8, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{4'h9, 4'h3, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{4'hD, 4'h9, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{4'hE, 4'h9, 4'h0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{4'hE, 4'h9, 4'h1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{4'hD, 4'h3, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{4'h4, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{4'h5, 4'h5, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{4'h5, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};

    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.alu_ctrl  = '0;
    io.out_ready = 1'b1;
    #12 rst_n = 1'b1;
    step();

    // traffic, then reset mid-stream
    drive(4'hF, 4'h5, 4'h0);
    step();
    drive(4'h4, 4'h7, 4'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_result", io.result, 0);
    chk("rst_flags", {io.flag_z, io.flag_n, io.flag_c, io.flag_v, io.err}, 0);
    io.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid_after", io.out_valid, 0);

    // streamed single-cycle vectors, ACC first proves acc was cleared
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("in_ready_v%0d", i), io.in_ready, 1);
      step();
      chk($sformatf("vec%0d", i),
          {io.out_valid, io.result, io.flag_z, io.flag_n,
           io.flag_c, io.flag_v, io.err},
          {1'b1, tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v, 1'b0});
    end
    io.in_valid = 1'b0;
    step();
    chk("drain_out_valid", io.out_valid, 0);

`ifdef ALU_REG_PIPE_MUL_EN
    drive(4'hC, 4'h5, 4'h3);
    chk("mul_in_ready", io.in_ready, 1);
    step();
    io.in_valid = 1'b0;
    lat  = 0;
    done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      step();
      if (io.out_valid) begin
        lat  = k;
        done = 1'b1;
      end else begin
        chk($sformatf("mul_busy%0d", k), io.in_ready, 0);
      end
    end
    chk("mul_latency", lat, 5);
    chk("mul_result", {io.result, io.flag_z, io.flag_n, io.err},
        {4'hF, 1'b0, 1'b1, 1'b0});
    step();
    // reset during multiply never yields a result
    drive(4'hC, 4'h7, 4'h7);
    step();
    io.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (io.out_valid) seen = 1'b1;
    end
    chk("mul_abort_no_result", seen, 0);
    chk("mul_abort_in_ready", io.in_ready, 1);
`else
    drive(4'hC, 4'h5, 4'h3);
    step();
    chk("mul_off", {io.out_valid, io.result, io.flag_z, io.err},
        {1'b1, 4'h0, 1'b1, 1'b1});
    drive(4'h4, 4'h1, 4'h1);
    step();
    chk("err_clears", {io.out_valid, io.result, io.err},
        {1'b1, 4'h2, 1'b0});
    io.in_valid = 1'b0;
    step();
`endif

    // output hold under backpressure; in_valid ignored meanwhile
    io.out_ready = 1'b0;
    drive(4'hD, 4'h9, 4'h1);
    step();
    drive(4'h4, 4'h1, 4'h1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d", k),
          {io.out_valid, io.result, io.flag_c, io.in_ready},
          {1'b1, 4'h2, 1'b1, 1'b0});
      step();
    end
    io.out_ready = 1'b1;
    #1;
    chk("hold_release_ready", io.in_ready, 1);
    step();
    chk("retire_and_load", {io.out_valid, io.result, io.flag_c},
        {1'b1, 4'h2, 1'b0});
    io.in_valid = 1'b0;
    step();
    chk("final_idle", io.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_reg_pipe.md
Name: alu_reg_pipe

Overview:
- Parametrised, registered successor to the combinational 4-bit ALU.
- Captures operands and opcode through a valid/ready input handshake and returns a registered result plus status flags through a valid/ready output handshake.
- Adds an accumulator, shifts and an iterative shift-add multiplier.
- Sits between the register file and the writeback register in the datapath practicals.

Parameters:
N, 8, operand/result width in bits, must be >= 2
SHW, $clog2(N), width of the shift-amount field taken from b[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode offered
in_ready  output  1  block can accept this cycle
a  input  N  operand A
b  input  N  operand B
alu_ctrl  input  4  opcode
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  N  registered result
flag_z  output  1  result == 0
flag_n  output  1  result[N-1]
flag_c  output  1  carry out (ADD), borrow (SUB), last bit shifted out (SHL/SHR); else 0
flag_v  output  1  signed overflow (ADD/SUB); else 0
err  output  1  illegal or disabled opcode captured

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, result=0, out_valid=0, all flags=0, err=0, accumulator=0. Asserting reset mid-multiply aborts it; no partial result is ever presented.
- Accept condition: in_valid & in_ready at a rising edge.
- in_ready = (state==IDLE) & (!out_valid | out_ready). A single-cycle op therefore streams one result per clock while the consumer keeps out_ready high.
- Opcodes 0000..1011 keep the existing map: NOT, AND, OR, XOR, ADD, SUB, LT, LTE, GT, GTE, EQ, NE.
  - Compare ops are unsigned and return zero-extended 0/1.
- New opcodes:
  - 1100 MUL: unsigned, lower N bits of a*b.
  - 1101 SHL: a << b[SHW-1:0].
  - 1110 SHR: logical a >> b[SHW-1:0].
  - 1111 ACC: result = acc + a, acc <= acc + a (mod 2^N), flags as ADD.
- Shifts: amount 0 gives result=a, flag_c=0.
- Latency: single-cycle ops present out_valid in the cycle after acceptance.
- Output hold: result, flags and err are held stable while out_valid=1 & out_ready=0. out_valid clears on out_ready unless a new result is loaded in the same edge.
- FSM:
  - IDLE: accept. A single-cycle op loads the output and stays in IDLE. MUL loads multiplicand, multiplier and partial product, sets count=N and goes to MUL.
  - MUL: one shift-add step per clock. When count reaches 0, go to DONE.
  - DONE: once !out_valid | out_ready, load result and flags, set out_valid, go to IDLE. Total accept-to-out_valid latency = N+1 cycles when the output is free.
- Flags are computed on the N-bit result. flag_z and flag_n apply to every op.
- err is set for a disabled opcode. The result is then 0, flags follow result=0 (flag_z=1), and err is cleared on the next loaded result.
- in_valid while in_ready=0 is ignored; no input is captured.
- Simultaneous out_ready and a new acceptance: the old result retires and the new result is loaded on the same edge.

Optional Feature:
- Macro: ALU_REG_PIPE_MUL_EN.
- Defined: MUL state and shift-add datapath are compiled in; opcode 1100 behaves as above.
- Undefined: no MUL state or datapath. Opcode 1100 completes in 1 cycle with result=0, flag_z=1, err=1.

Test Plan:
1. N=4, reset low mid-stream then released -> result=0, out_valid=0, flags 0, acc=0; in_ready=1 one cycle after release.
2. N=4, ADD a=0111 b=0001, out_ready=1 -> next cycle result=1000, flag_n=1, flag_v=1, flag_c=0, flag_z=0; SUB a=0000 b=0001 -> result=1111, flag_c=1.
3. N=4, back-to-back ACC a=0011 three times with out_ready=1 -> results 0011, 0110, 1001 on consecutive cycles; in_ready stays 1.
4. N=4, MUL a=0101 b=0011 (feature on) -> in_ready=0 for the busy cycles, out_valid exactly 5 cycles after acceptance, result=1111. Same test with the feature off -> result=0000, err=1, 1-cycle latency.
5. N=4, SHL a=1001 b=0001 with out_ready=0 for 3 cycles -> result=0010, flag_c=1 held stable; in_ready=0 until out_ready rises.
6. N=4, opcode LT a=0010 b=0101 -> result=0001; then EQ a=b=1010 -> result=0001; NE on the same operands -> result=0000, flag_z=1.
